count_checker: RTL and testbench

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_chk_pkg.sv | 25 ++
 rtl/count_checker_sat_counter.sv | 26 ++
 rtl/count_checker.sv | 151 +++++++++++++++
 tb/tb_count_checker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_chk_pkg.sv
// rtl/count_chk_pkg.sv - shared state encoding and default sizes for count_checker
package count_chk_pkg;

    // Default observed-counter width
    localparam int DEF_WIDTH  = 16;
    // Default consecutive good samples needed to regain lock
    localparam int DEF_LOCK_N = 4;
    // Default width of the statistics counters
    localparam int DEF_ERR_W  = 8;

    // IDLE captures the first sample, TRACK checks it, RESYNC hunts for a clean run
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        RESYNC = 2'd2
    } chk_state_t;

    // Width of a counter able to hold values 0..n (never less than one bit)
    function automatic int run_width(input int n);
        int w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/count_checker_sat_counter.sv
// rtl/count_checker_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] value
);

    localparam logic [W-1:0] MAX_VAL = '1;
    localparam logic [W-1:0] ONE     = W'(1);

    // Clear takes effect before the increment so an event on the clearing edge reads as 1
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (clr) begin
            value <= inc ? ONE : '0;
        end else if (inc && (value != MAX_VAL)) begin
            value <= value + ONE;
        end
    end

endmodule

// File: rtl/count_checker.sv
// rtl/count_checker.sv - monitors an external counter for lost increments (tc check: COUNT_CHECKER_TC_CHECK_EN)
module count_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LOCK_N = DEF_LOCK_N,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cnt_ena,
    input  logic [WIDTH-1:0] count,
    input  logic             tc,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] wrap_count
);

    localparam int               RUN_W    = run_width(LOCK_N);
    localparam logic [RUN_W-1:0] LOCK_V   = RUN_W'(LOCK_N);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    chk_state_t       state;
    chk_state_t       state_next;
    logic [WIDTH-1:0] ref_count;
    logic             ref_ena;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    logic [WIDTH-1:0] expected;
    logic             count_ok;
    logic             tc_ok;
    logic             sample_ok;
    logic             err_hit;
    logic             wrap_hit;

    // Value the counter must show now, given what it showed and was told last edge
    always_comb begin
        expected = ref_ena ? (ref_count + CNT_ONE) : ref_count;
        count_ok = (count == expected);
    end

`ifdef COUNT_CHECKER_TC_CHECK_EN
    // Terminal-count flag must agree with the sampled value being all ones
    always_comb begin
        tc_ok = (tc == (count == ALL_ONES));
    end
`else
    logic unused_tc;
    assign unused_tc = tc;
    assign tc_ok     = 1'b1;
`endif

    assign sample_ok = count_ok & tc_ok;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, run counter and event strobes
    always_comb begin
        state_next = state;
        run_next   = run_cnt;
        err_hit    = 1'b0;
        wrap_hit   = 1'b0;
        case (state)
            IDLE: begin
                state_next = TRACK;
                run_next   = '0;
            end
            TRACK: begin
                run_next = '0;
                if (!sample_ok) begin
                    state_next = RESYNC;
                    err_hit    = 1'b1;
                end else if ((ref_count == ALL_ONES) && (count == '0)) begin
                    wrap_hit = 1'b1;
                end
            end
            RESYNC: begin
                if (sample_ok) begin
                    if ((run_cnt + RUN_ONE) == LOCK_V) begin
                        state_next = TRACK;
                        run_next   = '0;
                    end else begin
                        run_next = run_cnt + RUN_ONE;
                    end
                end else begin
                    run_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                run_next   = '0;
            end
        endcase
    end

    // Reference sample, run counter and registered flags
    always_ff @(posedge clk) begin
        if (reset) begin
            ref_count  <= '0;
            ref_ena    <= 1'b0;
            run_cnt    <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            ref_count <= count;
            ref_ena   <= cnt_ena;
            run_cnt   <= run_next;
            locked    <= (state_next == TRACK);
            err_pulse <= err_hit;
            if (err_hit) begin
                err_sticky <= 1'b1;
            end else if (clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

    sat_counter #(
        .W(ERR_W)
    ) u_err_count (
        .clk  (clk),
        .reset(reset),
        .inc  (err_hit),
        .clr  (clr),
        .value(err_count)
    );

    sat_counter #(
        .W(ERR_W)
    ) u_wrap_count (
        .clk  (clk),
        .reset(reset),
        .inc  (wrap_hit),
        .clr  (clr),
        .value(wrap_count)
    );

endmodule

// File: tb/tb_count_checker.sv
// tb/tb_count_checker.sv - directed self-checking bench for count_checker
module tb_count_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        cnt_ena;
    logic [15:0] count;
    logic        tc;
    logic        clr;
    logic        locked;
    logic        err_pulse;
    logic        err_sticky;
    logic [7:0]  err_count;
    logic [7:0]  wrap_count;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    count_checker #(
        .WIDTH (16),
        .LOCK_N(4),
        .ERR_W (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_ena   (cnt_ena),
        .count     (count),
        .tc        (tc),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_sticky(err_sticky),
        .err_count (err_count),
        .wrap_count(wrap_count)
    );

    // Apply one sample with a consistent tc, then settle just past the edge
    task automatic drive(input int c, input bit e, input bit clr_v);
        count   = 16'(c);
        cnt_ena = e;
        tc      = (16'(c) == 16'hFFFF);
        clr     = clr_v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) drive(i * 37 + 5, 1'b1, 1'b1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3);
        n_total++;
        if ({locked, err_pulse, err_sticky} !== 3'b000) $display("FAIL reset_flags: got %b expected 000", {locked, err_pulse, err_sticky});
        else n_pass++;
        n_total++;
        if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d expected 0", err_count);
        else n_pass++;
        n_total++;
        if (wrap_count !== 8'd0) $display("FAIL reset_wrap_count: got %0d expected 0", wrap_count);
        else n_pass++;
    endtask

    task automatic test_ramp();
        drive(0, 1'b1, 1'b0);
        n_total++;
        if (locked !== 1'b1) $display("FAIL ramp_first_lock: got %b expected 1", locked);
        else n_pass++;
        for (int i = 1; i < 12; i++) begin
            drive(i, 1'b1, 1'b0);
            n_total++;
            if ({locked, err_pulse} !== 2'b10) $display("FAIL ramp_step%0d: locked,err_pulse got %b expected 10", i, {locked, err_pulse});
            else n_pass++;
        end
        n_total++;
        if (err_count !== 8'd0) $display("FAIL ramp_err_count: got %0d expected 0", err_count);
        else n_pass++;
    endtask

    task automatic test_jump();
        int seq [9] = '{10, 11, 30, 31, 32, 33, 34, 35, 36};
        bit exp_lock [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
        do_reset(1);
        for (int i = 0; i <= 5; i++) drive(i, 1'b1, 1'b0);
        drive(9, 1'b1, 1'b0);
        n_total++;
        if ({err_pulse, err_sticky, locked} !== 3'b110) $display("FAIL jump_flags: pulse,sticky,locked got %b expected 110", {err_pulse, err_sticky, locked});
        else n_pass++;
        n_total++;
        if (err_count !== 8'd1) $display("FAIL jump_err_count: got %0d expected 1", err_count);
        else n_pass++;
        // 10,11 are good, 30 breaks the run silently, then four good steps relock
        for (int i = 0; i < 9; i++) begin
            drive(seq[i], 1'b1, 1'b0);
            n_total++;
            if ({locked, err_pulse} !== {exp_lock[i], 1'b0}) $display("FAIL jump_resync%0d: locked,err_pulse got %b expected %b0", seq[i], {locked, err_pulse}, exp_lock[i]);
            else n_pass++;
        end
        n_total++;
        if ({err_count, err_sticky} !== {8'd1, 1'b1}) $display("FAIL jump_after_resync: err_count %0d sticky %b expected 1 1", err_count, err_sticky);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset(1);
        drive(65533, 1'b1, 1'b0);
        drive(65534, 1'b1, 1'b0);
        drive(65535, 1'b1, 1'b0);
        n_total++;
        if (wrap_count !== 8'd0) $display("FAIL wrap_before: got %0d expected 0", wrap_count);
        else n_pass++;
        drive(0, 1'b1, 1'b0);
        n_total++;
        if ({wrap_count, err_pulse, locked} !== {8'd1, 1'b0, 1'b1}) $display("FAIL wrap_at_zero: wrap %0d pulse %b locked %b expected 1 0 1", wrap_count, err_pulse, locked);
        else n_pass++;
        drive(1, 1'b1, 1'b0);
        n_total++;
        if ({wrap_count, err_count} !== {8'd1, 8'd0}) $display("FAIL wrap_after: wrap %0d err %0d expected 1 0", wrap_count, err_count);
        else n_pass++;
        // tc asserted at a value that is not all ones
        drive(2, 1'b1, 1'b0);
        count   = 16'd3;
        cnt_ena = 1'b1;
        tc      = 1'b1;
        clr     = 1'b0;
        @(posedge clk);
        #1;
`ifdef COUNT_CHECKER_TC_CHECK_EN
        n_total++;
        if ({err_count, err_pulse} !== {8'd1, 1'b1}) $display("FAIL tc_bad_flag: err %0d pulse %b expected 1 1", err_count, err_pulse);
        else n_pass++;
`else
        n_total++;
        if ({err_count, err_pulse} !== {8'd0, 1'b0}) $display("FAIL tc_ignored: err %0d pulse %b expected 0 0", err_count, err_pulse);
        else n_pass++;
`endif
    endtask

    task automatic test_hold();
        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            drive(7, 1'b0, 1'b0);
            n_total++;
            if ({locked, err_pulse} !== 2'b10) $display("FAIL hold_cycle%0d: locked,err_pulse got %b expected 10", i, {locked, err_pulse});
            else n_pass++;
        end
        drive(8, 1'b0, 1'b0);
        n_total++;
        if ({err_pulse, err_count, locked} !== {1'b1, 8'd1, 1'b0}) $display("FAIL hold_unexpected_step: pulse %b err %0d locked %b expected 1 1 0", err_pulse, err_count, locked);
        else n_pass++;
    endtask

    task automatic test_clr();
        do_reset(1);
        drive(65534, 1'b1, 1'b0);
        drive(65535, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b0);
        drive(1, 1'b1, 1'b0);
        drive(7, 1'b1, 1'b0);
        for (int v = 8; v <= 11; v++) drive(v, 1'b1, 1'b0);
        n_total++;
        if ({wrap_count, err_count, locked} !== {8'd1, 8'd1, 1'b1}) $display("FAIL clr_setup: wrap %0d err %0d locked %b expected 1 1 1", wrap_count, err_count, locked);
        else n_pass++;
        drive(20, 1'b1, 1'b1);
        n_total++;
        if ({err_count, err_sticky, err_pulse, wrap_count} !== {8'd1, 1'b1, 1'b1, 8'd0}) $display("FAIL clr_with_error: err %0d sticky %b pulse %b wrap %0d expected 1 1 1 0", err_count, err_sticky, err_pulse, wrap_count);
        else n_pass++;
        drive(21, 1'b1, 1'b1);
        n_total++;
        if ({err_count, err_sticky, wrap_count, locked} !== {8'd0, 1'b0, 8'd0, 1'b0}) $display("FAIL clr_alone: err %0d sticky %b wrap %0d locked %b expected 0 0 0 0", err_count, err_sticky, wrap_count, locked);
        else n_pass++;
        for (int v = 22; v <= 24; v++) drive(v, 1'b1, 1'b0);
        n_total++;
        if (locked !== 1'b1) $display("FAIL clr_keeps_run: locked got %b expected 1", locked);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset(1);
        for (int v = 0; v <= 3; v++) drive(v, 1'b1, 1'b0);
        drive(50, 1'b1, 1'b0);
        drive(51, 1'b1, 1'b0);
        reset = 1'b1;
        drive(52, 1'b1, 1'b0);
        reset = 1'b0;
        n_total++;
        if ({locked, err_pulse, err_sticky, err_count, wrap_count} !== 19'd0) $display("FAIL reset_mid_outputs: got %h expected 0", {locked, err_pulse, err_sticky, err_count, wrap_count});
        else n_pass++;
        drive(100, 1'b1, 1'b0);
        n_total++;
        if ({locked, err_pulse} !== 2'b10) $display("FAIL reset_mid_recapture: locked,err_pulse got %b expected 10", {locked, err_pulse});
        else n_pass++;
        for (int v = 101; v <= 104; v++) drive(v, 1'b1, 1'b0);
        n_total++;
        if ({locked, err_count} !== {1'b1, 8'd0}) $display("FAIL reset_mid_ramp: locked %b err %0d expected 1 0", locked, err_count);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int v = 0;
        do_reset(1);
        drive(v, 1'b1, 1'b0);
        for (int k = 0; k < 257; k++) begin
            v = (v + 100) % 60000;
            drive(v, 1'b1, 1'b0);
            for (int j = 0; j < 4; j++) begin
                v = v + 1;
                drive(v, 1'b1, 1'b0);
            end
            if (k == 253) begin
                n_total++;
                if (err_count !== 8'd254) $display("FAIL sat_below: got %0d expected 254", err_count);
                else n_pass++;
            end
        end
        n_total++;
        if ({err_count, locked} !== {8'd255, 1'b1}) $display("FAIL sat_hold: err %0d locked %b expected 255 1", err_count, locked);
        else n_pass++;
        v = v + 500;
        drive(v, 1'b1, 1'b0);
        n_total++;
        if ({err_count, err_pulse} !== {8'd255, 1'b1}) $display("FAIL sat_pulse: err %0d pulse %b expected 255 1", err_count, err_pulse);
        else n_pass++;
    endtask

    initial begin
        reset   = 1'b1;
        cnt_ena = 1'b0;
        count   = '0;
        tc      = 1'b0;
        clr     = 1'b0;
        test_reset();
        test_ramp();
        test_jump();
        test_wrap();
        test_hold();
        test_clr();
        test_reset_mid();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
